// File: rtl/servo_uart_rx_word.sv
// servo_uart_rx_word
// Receives the servo block's UART stream, recovers bytes and pairs them into
// 16-bit words, low byte first.
// The frame is 8N1 by default. Defining SERVO_RX_PARITY_EN switches it to 8E1
// and adds the parity_err output.
// Each byte is sampled mid-bit from a 2-flop synchronised copy of rx.
// A low byte left unpaired for TIMEOUT_BITS bit periods is dropped and reported.
module servo_uart_rx_word #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        frame_err,
    output logic        timeout_err,
`ifdef SERVO_RX_PARITY_EN
    output logic        parity_err,
`endif
    output logic        rx_busy
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef SERVO_RX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

`ifdef SERVO_RX_PARITY_EN
    // Even parity: data bits plus the parity bit must XOR to zero.
    function automatic logic even_parity_bad(input logic [7:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction
`endif

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              rx_s_q, rx_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        low_q, low_d;
    logic              pending_q, pending_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              brk_q, brk_d;
    logic [15:0]       word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;
    logic              rx_busy_q, rx_busy_d;
`ifdef SERVO_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Next-state logic: synchroniser, frame FSM, word pairing and pending-byte timeout.
    always_comb begin
        sync1_d       = rx;
        rx_s_d        = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        low_d         = low_q;
        pending_d     = pending_q;
        tmo_d         = tmo_q;
        brk_d         = brk_q;
        word_d        = word_q;
        word_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
`ifdef SERVO_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                brk_d = 1'b0;
                // A start edge beats a timeout expiring in the same cycle.
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else if (pending_q) begin
                    if (tmo_q == TMO_LAST) begin
                        pending_d     = 1'b0;
                        timeout_err_d = 1'b1;
                        tmo_d         = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went high again before mid start bit: glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef SERVO_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERVO_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = even_parity_bad(shift_q, rx_s_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (brk_q) begin
                    // After a bad stop bit, hold here until the line is idle so a
                    // held-low line cannot start another frame.
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        pending_d   = 1'b0;
                        brk_d       = 1'b1;
`ifdef SERVO_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        pending_d    = 1'b0;
                        state_d      = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        if (pending_q) begin
                            word_d       = {shift_q, low_q};
                            word_valid_d = 1'b1;
                            pending_d    = 1'b0;
                        end else begin
                            low_d     = shift_q;
                            pending_d = 1'b1;
                            tmo_d     = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        rx_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame and drops a pending byte.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            low_q         <= 8'h00;
            pending_q     <= 1'b0;
            tmo_q         <= '0;
            brk_q         <= 1'b0;
            word_q        <= 16'h0000;
            word_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            rx_busy_q     <= 1'b0;
`ifdef SERVO_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            low_q         <= low_d;
            pending_q     <= pending_d;
            tmo_q         <= tmo_d;
            brk_q         <= brk_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            rx_busy_q     <= rx_busy_d;
`ifdef SERVO_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign word_out    = word_q;
    assign word_valid  = word_valid_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign rx_busy     = rx_busy_q;
`ifdef SERVO_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_servo_uart_rx_word.sv
// Directed testbench for servo_uart_rx_word (CLKS_PER_BIT=8, TIMEOUT_BITS=4).
module tb_servo_uart_rx_word;
    localparam int CPB = 8;
    localparam int TOB = 4;

    logic        mclk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic        timeout_err;
    logic        rx_busy;
`ifdef SERVO_RX_PARITY_EN
    logic        parity_err;
    logic        bad_par = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int n_wv  = 0;
    int n_fe  = 0;
    int n_te  = 0;
    int n_pe  = 0;
    int n_ovl = 0;

    always #5 mclk = ~mclk;

    servo_uart_rx_word #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .mclk       (mclk),
        .reset      (reset),
        .rx         (rx),
        .word_out   (word_out),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
`ifdef SERVO_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .rx_busy    (rx_busy)
    );

    // Pulse counters sampled on the falling edge.
    always @(negedge mclk) begin
        int pe;
        pe = 0;
`ifdef SERVO_RX_PARITY_EN
        pe = int'(parity_err);
`endif
        if (word_valid)  n_wv++;
        if (frame_err)   n_fe++;
        if (timeout_err) n_te++;
        n_pe += pe;
        if ((int'(word_valid) + int'(frame_err) + int'(timeout_err) + pe) > 1) n_ovl++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SERVO_RX_PARITY_EN
        send_bit((^b) ^ bad_par);
`endif
        send_bit(stop_ok);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        tick(n * CPB);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        tick(3);
        checks++; if (word_out !== 16'h0000) begin failures++; $display("FAIL reset_word: got %h expected 0000", word_out); end
        checks++; if ({word_valid, frame_err, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b expected 000", {word_valid, frame_err, timeout_err}); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        reset = 1'b0;
        tick(3);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_basic_word;
        int wv0, fe0, te0;
        wv0 = n_wv; fe0 = n_fe; te0 = n_te;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle_bits(1);
        checks++; if (word_out !== 16'h1234) begin failures++; $display("FAIL basic_word: got %h expected 1234", word_out); end
        checks++; if (n_wv - wv0 !== 1) begin failures++; $display("FAIL basic_valid_count: got %0d expected 1", n_wv - wv0); end
        checks++; if ((n_fe - fe0) + (n_te - te0) !== 0) begin failures++; $display("FAIL basic_errors: got %0d expected 0", (n_fe - fe0) + (n_te - te0)); end
    endtask

    task automatic test_frame_err;
        int wv0, fe0, te0;
        wv0 = n_wv; fe0 = n_fe; te0 = n_te;
        send_byte(8'h99, 1'b1);
        send_byte(8'hA5, 1'b0);
        idle_bits(1);
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL frame_err_count: got %0d expected 1", n_fe - fe0); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_bits(1);
        checks++; if (word_out !== 16'h0201) begin failures++; $display("FAIL frame_next_word: got %h expected 0201", word_out); end
        checks++; if (n_wv - wv0 !== 1) begin failures++; $display("FAIL frame_valid_count: got %0d expected 1", n_wv - wv0); end
        checks++; if (n_te - te0 !== 0) begin failures++; $display("FAIL frame_timeout: got %0d expected 0", n_te - te0); end
    endtask

    task automatic test_timeout;
        int wv0, te0;
        wv0 = n_wv; te0 = n_te;
        send_byte(8'h55, 1'b1);
        idle_bits(5);
        checks++; if (n_te - te0 !== 1) begin failures++; $display("FAIL timeout_count: got %0d expected 1", n_te - te0); end
        checks++; if (word_out !== 16'h0201) begin failures++; $display("FAIL timeout_hold_word: got %h expected 0201", word_out); end
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        idle_bits(1);
        checks++; if (word_out !== 16'h7766) begin failures++; $display("FAIL timeout_word: got %h expected 7766", word_out); end
        checks++; if (n_wv - wv0 !== 1) begin failures++; $display("FAIL timeout_valid_count: got %0d expected 1", n_wv - wv0); end
        checks++; if (n_te - te0 !== 1) begin failures++; $display("FAIL timeout_total: got %0d expected 1", n_te - te0); end
    endtask

    task automatic test_glitch;
        int wv0, fe0, te0, rise, fall;
        wv0 = n_wv; fe0 = n_fe; te0 = n_te;
        rise = -1; fall = -1;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rx_busy && rise < 0) rise = i;
            if (!rx_busy && rise >= 0 && fall < 0) fall = i;
        end
        checks++; if (rise < 0) begin failures++; $display("FAIL glitch_busy_rise: got none expected rx_busy high"); end
        checks++; if (fall < 0 || (fall - rise) > CPB / 2 + 2) begin failures++; $display("FAIL glitch_busy_fall: got %0d cycles expected <= %0d", fall - rise, CPB / 2 + 2); end
        checks++; if ((n_wv - wv0) + (n_fe - fe0) + (n_te - te0) !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d expected 0", (n_wv - wv0) + (n_fe - fe0) + (n_te - te0)); end
        checks++; if (word_out !== 16'h7766) begin failures++; $display("FAIL glitch_word: got %h expected 7766", word_out); end
    endtask

    task automatic test_reset_mid;
        int wv0, fe0, te0;
        send_byte(8'h11, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
        reset = 1'b1;
        tick(2);
        checks++; if (word_out !== 16'h0000) begin failures++; $display("FAIL mid_reset_word: got %h expected 0000", word_out); end
        checks++; if ({word_valid, frame_err, timeout_err, rx_busy} !== 4'b0000) begin failures++; $display("FAIL mid_reset_outs: got %b expected 0000", {word_valid, frame_err, timeout_err, rx_busy}); end
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        wv0 = n_wv; fe0 = n_fe; te0 = n_te;
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        idle_bits(1);
        checks++; if (word_out !== 16'hBEEF) begin failures++; $display("FAIL mid_after_word: got %h expected beef", word_out); end
        checks++; if (n_wv - wv0 !== 1) begin failures++; $display("FAIL mid_valid_count: got %0d expected 1", n_wv - wv0); end
        checks++; if ((n_fe - fe0) + (n_te - te0) !== 0) begin failures++; $display("FAIL mid_errors: got %0d expected 0", (n_fe - fe0) + (n_te - te0)); end
    endtask

    task automatic test_break;
        int wv0, fe0;
        wv0 = n_wv; fe0 = n_fe;
        rx = 1'b0;
        tick(CPB * 25);
        rx = 1'b1;
        tick(CPB * 2);
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL break_frame_err: got %0d expected 1", n_fe - fe0); end
        checks++; if (n_wv - wv0 !== 0) begin failures++; $display("FAIL break_valid: got %0d expected 0", n_wv - wv0); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_busy: got %b expected 0", rx_busy); end
    endtask

`ifdef SERVO_RX_PARITY_EN
    task automatic test_parity;
        int wv0, pe0;
        wv0 = n_wv; pe0 = n_pe;
        bad_par = 1'b1;
        send_byte(8'h03, 1'b1);
        bad_par = 1'b0;
        idle_bits(1);
        checks++; if (n_pe - pe0 !== 1) begin failures++; $display("FAIL parity_err_count: got %0d expected 1", n_pe - pe0); end
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(1);
        checks++; if (word_out !== 16'h0003) begin failures++; $display("FAIL parity_word: got %h expected 0003", word_out); end
        checks++; if (n_wv - wv0 !== 1) begin failures++; $display("FAIL parity_valid_count: got %0d expected 1", n_wv - wv0); end
    endtask
`endif

    task automatic test_exclusive;
        checks++; if (n_ovl !== 0) begin failures++; $display("FAIL pulse_overlap: got %0d cycles expected 0", n_ovl); end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        test_reset;
        test_basic_word;
        test_frame_err;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_break;
`ifdef SERVO_RX_PARITY_EN
        test_parity;
`endif
        test_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_uart_rx_word.md
Name: servo_uart_rx_word

Overview:
- Downstream consumer of the servo block's UART serial output (Tx).
- Oversamples the 8N1 line and recovers bytes, then pairs consecutive bytes into the 16-bit words that the servo FIFO streamed out (low byte first).
- Flags framing errors and stale half-words, for loopback checking on the DE2-115 and for the host-side bridge.

Parameters:
- CLKS_PER_BIT, 434, mclk cycles per UART bit (50 MHz / 115200); minimum 4.
- TIMEOUT_BITS, 20, bit periods allowed between the stop bit of the low byte and the start bit of the high byte.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line from the servo Tx; idle high.
- word_out  out  16  last completed word, {high byte, low byte}.
- word_valid  out  1  one-cycle pulse when word_out updates.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- timeout_err  out  1  one-cycle pulse when a pending low byte is discarded.
- rx_busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset values:
  - word_out = 16'h0000.
  - word_valid, frame_err, timeout_err, rx_busy = 0.
  - Pending-byte flag cleared.
  - FSM in IDLE.
  - Synchronizer flops preset to 1.
- Reset mid-frame aborts the frame and discards any partial word.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- FSM states IDLE, START, DATA, STOP. Bit counter 0..CLKS_PER_BIT-1 and bit index 0..7.
- IDLE: on rx_s = 0, go to START and clear the counter.
- START: at count CLKS_PER_BIT/2-1 (mid start bit):
  - rx_s = 0: go to DATA, counter cleared.
  - rx_s = 1: glitch; return to IDLE with no error.
- DATA: sample at every count CLKS_PER_BIT-1, i.e. mid-bit. Shift in LSB first. After bit 7, go to STOP.
- STOP: sample at mid stop bit.
  - rx_s = 1: byte accepted.
  - rx_s = 0: frame_err pulse, byte discarded, pending flag cleared. Return to IDLE only once rx_s = 1, which prevents re-triggering on a held-low line.
- Byte accepted with no pending byte: store as low byte, set pending, start the timeout counter.
- Byte accepted with pending set:
  - word_out <= {byte, low}.
  - word_valid pulses on the cycle after the stop-bit sample.
  - Pending cleared.
- Timeout: with pending set and FSM in IDLE, the counter runs to TIMEOUT_BITS*CLKS_PER_BIT. On expiry: pending cleared, timeout_err pulses.
- If a start edge and timeout expiry land in the same cycle, the start edge wins. The counter is frozen while not IDLE.
- Latency: word_valid asserts 1 cycle after the high byte's mid-stop sample, about 9.5 bit times after its start edge plus 2 synchronizer cycles.
- word_out holds its value between pulses. word_valid, frame_err and timeout_err are never high in the same cycle.
- A break condition (rx low for longer than one frame) yields exactly one frame_err.

Optional Feature:
- Macro: SERVO_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A parity state between DATA and STOP samples one extra bit.
  - Adds port parity_err (out, 1), a one-cycle pulse when the XOR of the 8 data bits and the parity bit is 1.
  - On parity_err the byte is discarded and pending is cleared. STOP is still checked, and frame_err takes precedence if both fail.
- Undefined: 8N1 only; no parity state and no parity_err port.

Test Plan:
- Bench uses CLKS_PER_BIT=8, TIMEOUT_BITS=4.
- Basic word: send 0x34 then 0x12 back to back -> exactly one word_valid pulse; word_out = 16'h1234; no errors.
- Framing error: send 0xA5 with stop bit = 0, then 0x01, 0x02 -> one frame_err pulse; next word_out = 16'h0201; the bad byte is not used as a low byte.
- Timeout: send 0x55, idle 5 bit times, send 0x66, 0x77 -> timeout_err pulses once; word_out = 16'h7766.
- Glitch: rx low for 2 cycles in IDLE -> returns to IDLE; no pulses; rx_busy drops within CLKS_PER_BIT/2+2 cycles.
- Reset mid-operation: assert reset during DATA of the high byte, then send 0xEF, 0xBE -> all outputs at reset values during reset; word_out = 16'hBEEF afterwards.
- Parity (SERVO_RX_PARITY_EN): send 0x03 with parity bit 1 -> parity_err pulse; a correct 0x03 (parity 0) followed by 0x00 -> word_out = 16'h0003.
